// File: rtl/countdown_timer.sv
// Programmable down-counter with prescaler, start/stop control and sticky expiry irq; strobe effects land on the next edge.
// Optional macro COUNTDOWN_AUTO_RELOAD_EN: periodic mode, expiry reloads the last loaded value and keeps running.
module countdown_timer #(
    parameter int                       COUNTER_WIDTH = 16,
    parameter int                       DIVIDER_WIDTH = 15,
    parameter logic [DIVIDER_WIDTH-1:0] INTERVAL      = 15'd24000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [COUNTER_WIDTH-1:0] load_value,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     irq_ack,
    output logic [COUNTER_WIDTH-1:0] counter,
    output logic                     running,
    output logic                     irq
);

    logic [DIVIDER_WIDTH-1:0] divider;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [COUNTER_WIDTH-1:0] reload;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            divider <= '0;
            running <= 1'b0;
            irq     <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            reload  <= '0;
`endif
        end else begin
            // An expiry later in this block re-sets irq, so a coincident ack loses.
            if (irq_ack) begin
                irq <= 1'b0;
            end

            if (load) begin
                counter <= load_value;
                divider <= '0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                reload  <= load_value;
`endif
                if (load_value == '0 || stop) begin
                    running <= 1'b0;
                end else if (start) begin
                    running <= 1'b1;
                end
            end else if (stop) begin
                // Divider is left untouched so a later start resumes the partial period.
                running <= 1'b0;
            end else begin
                if (start && counter != '0) begin
                    running <= 1'b1;
                end
                if (running) begin
                    if (divider == INTERVAL) begin
                        divider <= '0;
                        if (counter > COUNTER_WIDTH'(1)) begin
                            counter <= counter - 1'b1;
                        end else begin
                            irq <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            counter <= reload;
`else
                            counter <= '0;
                            running <= 1'b0;
`endif
                        end
                    end else begin
                        divider <= divider + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with INTERVAL=3 (one tick every 4 clocks).
module tb_countdown_timer;

    localparam int CW = 16;
    localparam int DW = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load = 1'b0;
    logic [CW-1:0] load_value = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          irq_ack = 1'b0;
    logic [CW-1:0] counter;
    logic          running;
    logic          irq;

    int n_checks = 0;
    int n_fail   = 0;

    countdown_timer #(
        .COUNTER_WIDTH(CW),
        .DIVIDER_WIDTH(DW),
        .INTERVAL     (15'd3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .stop      (stop),
        .irq_ack   (irq_ack),
        .counter   (counter),
        .running   (running),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // One record: strobes applied for the first cycle, then idle until 'hold' edges
    // have passed; expected state is checked after the last of them.
    typedef struct {
        logic          rst;
        logic          ld;
        logic [CW-1:0] val;
        logic          st;
        logic          sp;
        logic          ack;
        int            hold;
        logic [CW-1:0] c;
        logic          r;
        logic          i;
        logic [DW-1:0] d;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Entered and left on a falling edge, so inputs change away from posedge.
    task automatic step(input vec_t v, input string tag);
        reset      = v.rst;
        load       = v.ld;
        load_value = v.val;
        start      = v.st;
        stop       = v.sp;
        irq_ack    = v.ack;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            reset   = 1'b0;
            load    = 1'b0;
            start   = 1'b0;
            stop    = 1'b0;
            irq_ack = 1'b0;
        end
        chk({tag, ".counter"}, 32'(counter),     32'(v.c));
        chk({tag, ".running"}, 32'(running),     32'(v.r));
        chk({tag, ".irq"},     32'(irq),         32'(v.i));
        chk({tag, ".divider"}, 32'(dut.divider), 32'(v.d));
    endtask

    task automatic idle(input int n, input logic [CW-1:0] c, input logic r, input logic i,
                        input logic [DW-1:0] d, input string tag);
        step('{1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, n, c, r, i, d}, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //                rst ld val st sp ack hold   c  r  i  d
        tbl.push_back('{1, 0, 0, 0, 0, 0, 1,    0, 0, 0, 0}); // reset
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        tbl.push_back('{0, 1, 1, 0, 0, 0, 1,    1, 0, 0, 0}); // build up irq=1
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    1, 1, 0, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1,    0, 0, 1, 0});
        tbl.push_back('{0, 1, 5, 0, 0, 0, 1,    5, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    5, 1, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 2,    5, 1, 1, 2});
        tbl.push_back('{1, 0, 0, 1, 0, 0, 1,    0, 0, 0, 0}); // reset mid-count beats start
        tbl.push_back('{0, 1, 3, 0, 0, 0, 1,    3, 0, 0, 0}); // load 3, start
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    3, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    3, 1, 0, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1,    2, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4,    1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    1, 1, 0, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1,    0, 0, 1, 0}); // expiry
        tbl.push_back('{0, 0, 0, 0, 0, 0, 5,    0, 0, 1, 0}); // stays expired
        tbl.push_back('{0, 0, 0, 0, 0, 1, 1,    0, 0, 0, 0}); // ack
        tbl.push_back('{0, 1, 1, 0, 0, 0, 1,    1, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    1, 1, 0, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 1,    0, 0, 1, 0}); // ack in expiry cycle
        tbl.push_back('{0, 0, 0, 0, 0, 1, 1,    0, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    0, 0, 0, 0}); // start with counter=0
        tbl.push_back('{0, 1, 6, 0, 0, 0, 1,    6, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    6, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 2,    6, 1, 0, 2});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 1,    0, 0, 0, 0}); // load 0 while running
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4,    0, 0, 0, 0});
        tbl.push_back('{0, 1, 9, 0, 0, 0, 1,    9, 0, 0, 0});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    9, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    9, 1, 0, 3});
        tbl.push_back('{0, 1, 7, 0, 0, 0, 1,    7, 1, 0, 0}); // load in tick cycle
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    7, 1, 0, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1,    6, 1, 0, 0});
        tbl.push_back('{0, 1, 2, 1, 0, 0, 1,    2, 1, 0, 0}); // load with start
        tbl.push_back('{0, 0, 0, 1, 1, 0, 1,    2, 0, 0, 0}); // stop beats start
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    2, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    2, 1, 0, 3});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 1,    2, 0, 0, 3}); // stop in tick cycle
        tbl.push_back('{0, 0, 0, 0, 0, 0, 5,    2, 0, 0, 3});
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    2, 1, 0, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 1,    1, 1, 0, 0}); // resume ticks at once
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4,    0, 0, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 1,    0, 0, 0, 0});
        tbl.push_back('{0, 1, 16'hffff, 1, 0, 0, 1, 16'hffff, 1, 0, 0}); // full-width value
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4,    16'hfffe, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 1,    16'hfffe, 0, 0, 0});
        tbl.push_back('{0, 1, 0, 0, 0, 0, 1,    0, 0, 0, 0});
`else
        tbl.push_back('{0, 1, 2, 0, 0, 0, 1,    2, 0, 0, 0}); // periodic: load 2, start
        tbl.push_back('{0, 0, 0, 1, 0, 0, 1,    2, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4,    1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4,    2, 1, 1, 0}); // reload edge
        tbl.push_back('{0, 0, 0, 0, 0, 1, 1,    2, 1, 0, 1});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    1, 1, 0, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4,    2, 1, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 0, 0, 3,    2, 1, 1, 3});
        tbl.push_back('{0, 0, 0, 0, 0, 1, 1,    1, 1, 0, 0}); // tick alongside ack
        tbl.push_back('{0, 0, 0, 0, 0, 0, 4,    2, 1, 1, 0});
        tbl.push_back('{0, 0, 0, 0, 1, 0, 1,    2, 0, 1, 0}); // only stop ends it
        tbl.push_back('{0, 0, 0, 0, 0, 0, 8,    2, 0, 1, 0});
        tbl.push_back('{0, 1, 0, 1, 0, 1, 1,    0, 0, 0, 0}); // reload 0 cannot run
`endif

        @(negedge clk);
        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n], $sformatf("row%0d", n));
        end

`ifndef COUNTDOWN_AUTO_RELOAD_EN
        // Stop/resume keeps the partial prescaler period.
        step('{1'b0, 1'b1, 16'd4, 1'b0, 1'b0, 1'b0, 1, 16'd4, 1'b0, 1'b0, 15'd0}, "sr.load");
        step('{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1, 16'd4, 1'b1, 1'b0, 15'd0}, "sr.start");
        idle(6, 16'd3, 1'b1, 1'b0, 15'd2, "sr.run6");
        step('{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 1, 16'd3, 1'b0, 1'b0, 15'd2}, "sr.stop");
        for (int k = 0; k < 20; k++) begin
            idle(1, 16'd3, 1'b0, 1'b0, 15'd2, $sformatf("sr.frozen%0d", k));
        end
        step('{1'b0, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0, 1, 16'd3, 1'b1, 1'b0, 15'd2}, "sr.resume");
        idle(1, 16'd3, 1'b1, 1'b0, 15'd3, "sr.r1");
        idle(1, 16'd2, 1'b1, 1'b0, 15'd0, "sr.r2");
        idle(4, 16'd1, 1'b1, 1'b0, 15'd0, "sr.r6");
        idle(3, 16'd1, 1'b1, 1'b0, 15'd3, "sr.r9");
        idle(1, 16'd0, 1'b0, 1'b1, 15'd0, "sr.r10");
        idle(6, 16'd0, 1'b0, 1'b1, 15'd0, "sr.after");
`else
        // Counter never reads 0 while running across several periods.
        step('{1'b0, 1'b1, 16'd3, 1'b1, 1'b0, 1'b0, 1, 16'd3, 1'b1, 1'b0, 15'd0}, "per.load3");
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            chk($sformatf("per.nonzero%0d", k), 32'(counter != '0 && running), 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
